fifo_write_arbiter: RTL and testbench

- Round-robin write arbiter that shares one synchronous FIFO write port between NUM_REQ producers.
- Grants one requester at a time for a burst of up to BURST_LEN beats.
- Drives the FIFO's write enable and write data, and respects the FIFO's FULL flag.
- Sits directly in front of the team's synchronous FIFO; read side untouched.

---
 rtl/fifo_write_arbiter_pkg.sv | 14 +
 rtl/rr_priority_pick.sv | 34 +++
 rtl/fifo_write_arbiter.sv | 127 ++++++++++++
 tb/tb_fifo_write_arbiter.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_write_arbiter_pkg.sv
// Shared defaults, state encoding and stats width for the FIFO write arbiter.
package fifo_write_arbiter_pkg;

  localparam int unsigned NUM_REQ_DEF    = 4;
  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned BURST_LEN_DEF  = 4;
  localparam int unsigned WR_COUNT_W     = 16;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_e;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin pick: first set request scanning up from rr_ptr, modulo NUM_REQ.
module rr_priority_pick #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned PTR_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic               valid
);

  logic [PTR_W:0]   sum;
  logic [PTR_W-1:0] idx;

  always_comb begin
    winner = '0;
    valid  = 1'b0;
    sum    = '0;
    idx    = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      // One spare bit so the wrap works for non-power-of-two NUM_REQ.
      sum = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (sum >= (PTR_W+1)'(NUM_REQ)) begin
        sum = sum - (PTR_W+1)'(NUM_REQ);
      end
      idx = sum[PTR_W-1:0];
      if (!valid && req[idx]) begin
        winner[idx] = 1'b1;
        valid       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter in front of a synchronous FIFO write port.
// Optional FIFO_ARB_STATS_EN adds a wrapping 16-bit WR_COUNT of FIFO writes.
module fifo_write_arbiter
  import fifo_write_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ    = NUM_REQ_DEF,
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned BURST_LEN  = BURST_LEN_DEF
) (
  input  logic                          FCLK,
  input  logic                          FRST,
  input  logic [NUM_REQ-1:0]            REQ,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] REQ_DATA,
  output logic [NUM_REQ-1:0]            ACK,
  output logic [NUM_REQ-1:0]            GRANT,
  input  logic                          FIFO_FULL,
  output logic                          FIFO_WR_EN,
`ifdef FIFO_ARB_STATS_EN
  output logic [WR_COUNT_W-1:0]         WR_COUNT,
`endif
  output logic [DATA_WIDTH-1:0]         FIFO_DATA
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(BURST_LEN) + 1;

  arb_state_e         state_q, state_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [CNT_W-1:0]   beat_cnt_q, beat_cnt_d;

  logic [NUM_REQ-1:0] pick_winner;
  logic               pick_valid;
  logic [PTR_W-1:0]   owner;
  logic               owner_req;

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .req    (REQ),
    .rr_ptr (rr_ptr_q),
    .winner (pick_winner),
    .valid  (pick_valid)
  );

  // A beat asserted during reset must not reach the FIFO.
  always_comb begin
    ACK       = '0;
    FIFO_DATA = '0;
    owner     = '0;
    owner_req = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        owner     = PTR_W'(i);
        owner_req = REQ[i];
      end
    end
    if (state_q == ARB_BURST && !FRST && !FIFO_FULL) begin
      ACK = grant_q & REQ;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ACK[i]) begin
        FIFO_DATA = REQ_DATA[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
    FIFO_WR_EN = |ACK;
  end

  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    beat_cnt_d = beat_cnt_q;
    case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          grant_d    = pick_winner;
          beat_cnt_d = '0;
          state_d    = ARB_BURST;
        end
      end
      ARB_BURST: begin
        if (!owner_req || (FIFO_WR_EN && beat_cnt_q == CNT_W'(BURST_LEN - 1))) begin
          state_d    = ARB_IDLE;
          grant_d    = '0;
          beat_cnt_d = '0;
          rr_ptr_d   = (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + 1'b1;
        end else if (FIFO_WR_EN) begin
          beat_cnt_d = beat_cnt_q + 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge FCLK) begin
    if (FRST) begin
      state_q    <= ARB_IDLE;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      beat_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      beat_cnt_q <= beat_cnt_d;
    end
  end

  assign GRANT = grant_q;

`ifdef FIFO_ARB_STATS_EN
  logic [WR_COUNT_W-1:0] wr_count_q;

  always_ff @(posedge FCLK) begin
    if (FRST) begin
      wr_count_q <= '0;
    end else if (FIFO_WR_EN) begin
      wr_count_q <= wr_count_q + 1'b1;
    end
  end

  assign WR_COUNT = wr_count_q;
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic against an integer-level model.
module tb_fifo_write_arbiter;

  localparam int N  = 4;
  localparam int DW = 8;
  localparam int BL = 4;

  logic          FCLK = 1'b0;
  logic          FRST;
  logic [N-1:0]  REQ;
  logic [N*DW-1:0] REQ_DATA;
  logic [N-1:0]  ACK;
  logic [N-1:0]  GRANT;
  logic          FIFO_FULL;
  logic          FIFO_WR_EN;
  logic [DW-1:0] FIFO_DATA;
`ifdef FIFO_ARB_STATS_EN
  logic [15:0]   WR_COUNT;
`endif

  fifo_write_arbiter dut (
    .FCLK       (FCLK),
    .FRST       (FRST),
    .REQ        (REQ),
    .REQ_DATA   (REQ_DATA),
    .ACK        (ACK),
    .GRANT      (GRANT),
    .FIFO_FULL  (FIFO_FULL),
    .FIFO_WR_EN (FIFO_WR_EN),
`ifdef FIFO_ARB_STATS_EN
    .WR_COUNT   (WR_COUNT),
`endif
    .FIFO_DATA  (FIFO_DATA)
  );

  always #5 FCLK = ~FCLK;

  int checks = 0;
  int errors = 0;

  // Model: owner index (-1 = idle), beats written in this burst, round-robin start.
  int m_owner = -1;
  int m_beats = 0;
  int m_ptr   = 0;
  int unsigned nwr = 0;

  logic [7:0]   pdata [N];
  logic [7:0]   wq [$];
  logic [N-1:0] exp_ack;
  logic [N-1:0] exp_grant;
  logic [7:0]   exp_data;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_exit();
    m_ptr   = (m_owner + 1) % N;
    m_owner = -1;
    m_beats = 0;
  endtask

  // Inputs are set at the negedge before calling; checks combinational and registered
  // outputs, steps the model across the rising edge, and returns at the next negedge.
  task automatic cycle();
    logic [1:0] own;
    for (int i = 0; i < N; i++) REQ_DATA[i*DW +: DW] = pdata[i];
    #1;
    own       = m_owner[1:0];
    exp_grant = '0;
    exp_ack   = '0;
    exp_data  = '0;
    if (m_owner >= 0) exp_grant[own] = 1'b1;
    if (!FRST && m_owner >= 0 && REQ[own] && !FIFO_FULL) begin
      exp_ack[own] = 1'b1;
      exp_data     = pdata[own];
    end
    check("grant", 32'(GRANT), 32'(exp_grant));
    check("ack", 32'(ACK), 32'(exp_ack));
    check("wr_en", 32'(FIFO_WR_EN), 32'(|exp_ack));
    check("fifo_data", 32'(FIFO_DATA), 32'(exp_data));
`ifdef FIFO_ARB_STATS_EN
    check("wr_count", 32'(WR_COUNT), 32'(nwr[15:0]));
`endif
    @(posedge FCLK);
    if (FRST) begin
      m_owner = -1;
      m_ptr   = 0;
      m_beats = 0;
      nwr     = 0;
    end else if (m_owner < 0) begin
      for (int k = 0; k < N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (m_owner < 0 && REQ[idx[1:0]]) m_owner = idx;
      end
      m_beats = 0;
    end else if (!REQ[own]) begin
      model_exit();
    end else if (exp_ack != '0) begin
      nwr++;
      wq.push_back(exp_data);
      pdata[own] = pdata[own] + 8'd1;
      m_beats++;
      if (m_beats == BL) model_exit();
    end
    @(negedge FCLK);
  endtask

  task automatic reset_pulse();
    REQ  = '0;
    FRST = 1'b1;
    cycle();
    FRST = 1'b0;
  endtask

  initial begin
    FRST      = 1'b1;
    REQ       = 4'b1111;
    FIFO_FULL = 1'b0;
    REQ_DATA  = '0;
    for (int i = 0; i < N; i++) pdata[i] = 8'h00;
    @(negedge FCLK);

    // Reset held for two cycles with all requests high.
    cycle();
    cycle();
    FRST = 1'b0;
    cycle();
    check("first_grant", 32'(GRANT), 32'h1);

    // Single requester: two full bursts separated by one bubble.
    reset_pulse();
    pdata[2] = 8'h10;
    REQ      = 4'b0100;
    wq.delete();
    repeat (11) cycle();
    check("burst_writes", 32'(wq.size()), 32'd8);
    for (int j = 0; j < 8 && j < wq.size(); j++) begin
      check("burst_data", 32'(wq[j]), 32'h10 + 32'(j));
    end

    // All requesting: rotate through owners.
    reset_pulse();
    REQ = 4'b1111;
    repeat (25) cycle();

    // Backpressure after two beats.
    reset_pulse();
    pdata[1] = 8'h40;
    REQ      = 4'b0010;
    repeat (3) cycle();
    FIFO_FULL = 1'b1;
    repeat (3) begin
      cycle();
      check("bp_grant_hold", 32'(GRANT), 32'h2);
    end
    FIFO_FULL = 1'b0;
    repeat (2) cycle();
    check("bp_exit", 32'(GRANT), 32'h0);

    // Early release by owner 3, requester 0 waiting; pointer wraps to 0.
    reset_pulse();
    REQ = 4'b1000;
    cycle();
    cycle();
    REQ = 4'b0001;
    cycle();
    check("early_idle", 32'(GRANT), 32'h0);
    cycle();
    check("early_wrap_grant", 32'(GRANT), 32'h1);

    // Random traffic, backpressure and occasional reset.
    reset_pulse();
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < N; i++) begin
        if (REQ[i] && exp_ack[i]) begin
          REQ[i] = ($urandom_range(0, 3) != 0);
        end else if (REQ[i]) begin
          REQ[i] = ($urandom_range(0, 15) != 0);
        end else if ($urandom_range(0, 2) == 0) begin
          pdata[i] = 8'($urandom);
          REQ[i]   = 1'b1;
        end
      end
      FIFO_FULL = ($urandom_range(0, 3) == 0);
      FRST      = ($urandom_range(0, 199) == 0);
      cycle();
    end
    FRST      = 1'b0;
    FIFO_FULL = 1'b0;

`ifdef FIFO_ARB_STATS_EN
    reset_pulse();
    REQ = 4'b1111;
    for (int n = 0; n < 95000 && nwr < 70000; n++) cycle();
    check("wr_count_wrap", 32'(WR_COUNT), 32'd4464);
    FRST = 1'b1;
    cycle();
    FRST = 1'b0;
    #1;
    check("wr_count_clear", 32'(WR_COUNT), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
